// File: rtl/ama_riscv_store_shift_mask_pkg.sv
// Shared store/load-path definitions: access width encodings, byte-offset
// constants, the store FSM state enum and small alignment/mask helpers.
package ama_riscv_store_shift_mask_pkg;

  localparam int OFFSET_W = 2;
  localparam logic [OFFSET_W-1:0] OFFSET_0 = 2'd0;
  localparam logic [OFFSET_W-1:0] OFFSET_3 = 2'd3;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2,
    RSVD = 2'd3
  } store_width_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } store_state_t;

  // A half crossing into the next word, or any word not on a word boundary.
  function automatic logic is_unaligned(input store_width_t width,
                                        input logic [OFFSET_W-1:0] offset);
    logic res;
    case (width)
      HALF:    res = (offset == OFFSET_3);
      WORD:    res = (offset != OFFSET_0);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] base_mask(input store_width_t width);
    logic [3:0] res;
    case (width)
      BYTE:    res = 4'b0001;
      HALF:    res = 4'b0011;
      WORD:    res = 4'b1111;
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ama_riscv_store_shift_mask_if.sv
// Data-memory write request bus between the store unit (master) and memory (slave).
interface ama_riscv_store_shift_mask_if;
  logic        dmem_valid;
  logic        dmem_ready;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_we;

  modport master (output dmem_valid, output dmem_addr, output dmem_wdata,
                  output dmem_we, input dmem_ready);
  modport slave  (input dmem_valid, input dmem_addr, input dmem_wdata,
                  input dmem_we, output dmem_ready);
endinterface

// File: rtl/ama_riscv_store_lane_gen.sv
// Combinational lane placement: right-aligned store data and its byte mask are
// shifted into a two-word window (low half = beat 0, high half = beat 1).
module ama_riscv_store_lane_gen
  import ama_riscv_store_shift_mask_pkg::*;
(
  input  logic [OFFSET_W-1:0] offset,
  input  logic [1:0]          width,
  input  logic [31:0]         data,
  output logic [63:0]         lane_data,
  output logic [7:0]          lane_mask
);

  logic [3:0]  base_s;
  logic [31:0] data_masked_s;

  // Bytes above the access width are cleared so unwritten lanes carry zero.
  always_comb begin
    base_s        = base_mask(store_width_t'(width));
    data_masked_s = data & {{8{base_s[3]}}, {8{base_s[2]}},
                            {8{base_s[1]}}, {8{base_s[0]}}};
    lane_data     = {32'd0, data_masked_s} << {offset, 3'd0};
    lane_mask     = {4'd0, base_s} << offset;
  end

endmodule

// File: rtl/ama_riscv_store_shift_mask.sv
// Store shift/mask unit: turns a core store into lane-aligned dmem write beats.
// Define AMA_RISCV_STORE_SPLIT_EN to split unaligned stores into two beats;
// otherwise they are dropped and flagged with a one-cycle unaligned pulse.
module ama_riscv_store_shift_mask
  import ama_riscv_store_shift_mask_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [31:0]                  addr,
  input  logic [1:0]                   width,
  input  logic [31:0]                  data_in,
  ama_riscv_store_shift_mask_if.master dmem,
  output logic                         busy,
  output logic                         unaligned
);

  store_state_t state_r;
  store_state_t state_nxt_s;
  logic         accept_s;
  logic         unaligned_s;
  logic         issue_s;
  logic         split_s;
  logic         unaligned_pulse_s;
  logic         hs_s;
  logic [63:0]  lane_data_s;
  logic [7:0]   lane_mask_s;
  logic [31:0]  hi_wdata_r;
  logic [3:0]   hi_we_r;
  logic         split_r;

  ama_riscv_store_lane_gen u_lane_gen (
    .offset    (addr[1:0]),
    .width     (width),
    .data      (data_in),
    .lane_data (lane_data_s),
    .lane_mask (lane_mask_s)
  );

  // Acceptance decode and next-state logic.
  always_comb begin
    accept_s    = en && (state_r == IDLE);
    unaligned_s = is_unaligned(store_width_t'(width), addr[1:0]);
    hs_s        = dmem.dmem_valid && dmem.dmem_ready;
`ifdef AMA_RISCV_STORE_SPLIT_EN
    issue_s           = accept_s && (store_width_t'(width) != RSVD);
    split_s           = unaligned_s;
    unaligned_pulse_s = 1'b0;
`else
    issue_s           = accept_s && (store_width_t'(width) != RSVD) && !unaligned_s;
    split_s           = 1'b0;
    unaligned_pulse_s = accept_s && unaligned_s;
`endif
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (issue_s) state_nxt_s = BEAT0;
        else         state_nxt_s = IDLE;
      end
      BEAT0: begin
        if (hs_s) state_nxt_s = split_r ? BEAT1 : IDLE;
        else      state_nxt_s = BEAT0;
      end
      BEAT1: begin
        if (hs_s) state_nxt_s = IDLE;
        else      state_nxt_s = BEAT1;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Registered bus outputs; beat-1 lanes are captured at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem.dmem_valid <= 1'b0;
      dmem.dmem_addr  <= 30'd0;
      dmem.dmem_wdata <= 32'd0;
      dmem.dmem_we    <= 4'd0;
      hi_wdata_r      <= 32'd0;
      hi_we_r         <= 4'd0;
      split_r         <= 1'b0;
      busy            <= 1'b0;
      unaligned       <= 1'b0;
    end else begin
      busy      <= (state_nxt_s != IDLE);
      unaligned <= unaligned_pulse_s;
      case (state_r)
        IDLE: begin
          if (issue_s) begin
            dmem.dmem_valid <= 1'b1;
            dmem.dmem_addr  <= addr[31:2];
            dmem.dmem_wdata <= lane_data_s[31:0];
            dmem.dmem_we    <= lane_mask_s[3:0];
            hi_wdata_r      <= lane_data_s[63:32];
            hi_we_r         <= lane_mask_s[7:4];
            split_r         <= split_s;
          end
        end
        BEAT0: begin
          if (hs_s) begin
            if (split_r) begin
              // 30-bit add wraps the top word address to zero.
              dmem.dmem_addr  <= dmem.dmem_addr + 30'd1;
              dmem.dmem_wdata <= hi_wdata_r;
              dmem.dmem_we    <= hi_we_r;
            end else begin
              dmem.dmem_valid <= 1'b0;
            end
          end
        end
        BEAT1: begin
          if (hs_s) dmem.dmem_valid <= 1'b0;
        end
        default: dmem.dmem_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ama_riscv_store_shift_mask.sv
// Directed bench for ama_riscv_store_shift_mask: expected beats are queued when a
// store is driven and checked at each handshake. Honours AMA_RISCV_STORE_SPLIT_EN.
module tb_ama_riscv_store_shift_mask;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] addr;
  logic [1:0]  width;
  logic [31:0] data_in;
  logic        busy;
  logic        unaligned;

  ama_riscv_store_shift_mask_if bus ();

  ama_riscv_store_shift_mask dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .addr      (addr),
    .width     (width),
    .data_in   (data_in),
    .dmem      (bus),
    .busy      (busy),
    .unaligned (unaligned)
  );

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  we;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       e;
  int          n_assert = 0;
  int          n_fail   = 0;
  logic        prev_pend = 1'b0;
  logic [29:0] prev_a;
  logic [31:0] prev_d;
  logic [3:0]  prev_we;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    addr    = a;
    width   = w;
    data_in = d;
    en      = 1'b1;
  endtask

  task automatic push(input logic [29:0] a, input logic [31:0] d, input logic [3:0] we);
    beat_t b;
    b.a  = a;
    b.d  = d;
    b.we = we;
    exp_q.push_back(b);
  endtask

  // accept with ready=1, then the single handshake cycle
  task automatic run_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    drive(a, w, d);
    step();
    en = 1'b0;
    step();
  endtask

  // Scoreboard monitor: stability under backpressure and beat contents at handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        chk("hold_valid", 32'(bus.dmem_valid), 32'd1);
        chk("hold_addr",  32'(bus.dmem_addr),  32'(prev_a));
        chk("hold_wdata", bus.dmem_wdata,      prev_d);
        chk("hold_we",    32'(bus.dmem_we),    32'(prev_we));
      end
      if (bus.dmem_valid && bus.dmem_ready) begin
        n_assert++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_beat: observed addr 0x%0h expected no request", bus.dmem_addr);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_addr",  32'(bus.dmem_addr), 32'(e.a));
          chk("beat_wdata", bus.dmem_wdata,     e.d);
          chk("beat_we",    32'(bus.dmem_we),   32'(e.we));
        end
      end
      prev_pend = bus.dmem_valid && !bus.dmem_ready;
      prev_a    = bus.dmem_addr;
      prev_d    = bus.dmem_wdata;
      prev_we   = bus.dmem_we;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; addr = 32'd0; width = 2'd0; data_in = 32'd0;
    bus.dmem_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("rst_valid", 32'(bus.dmem_valid), 32'd0);
    chk("rst_addr",  32'(bus.dmem_addr),  32'd0);
    chk("rst_wdata", bus.dmem_wdata,      32'd0);
    chk("rst_we",    32'(bus.dmem_we),    32'd0);
    chk("rst_busy",  32'(busy),           32'd0);
    chk("rst_unal",  32'(unaligned),      32'd0);
    step();
    rst = 1'b0;

    // byte at offset 3, latency 1, busy drops after handshake
    bus.dmem_ready = 1'b1;
    drive(32'h0000_1003, 2'd0, 32'h0000_00AB);
    push(30'h400, 32'hAB00_0000, 4'b1000);
    step();
    en = 1'b0;
    @(negedge clk);
    chk("byte_valid", 32'(bus.dmem_valid), 32'd1);
    chk("byte_busy",  32'(busy),           32'd1);
    step();
    @(negedge clk);
    chk("byte_valid_drop", 32'(bus.dmem_valid), 32'd0);
    chk("byte_busy_drop",  32'(busy),           32'd0);
    step();

    push(30'h004, 32'h0000_005A, 4'b0001);
    run_store(32'h0000_0010, 2'd0, 32'hFFFF_FF5A);
    push(30'h040, 32'hDEAD_BEEF, 4'b1111);
    run_store(32'h0000_0100, 2'd2, 32'hDEAD_BEEF);
    push(30'h800, 32'h0056_7800, 4'b0110);
    run_store(32'h0000_2001, 2'd1, 32'h1234_5678);
    push(30'h001, 32'h9900_0000, 4'b1000);
    run_store(32'h0000_0007, 2'd0, 32'h0000_0099);

    // backpressure for 3 cycles with en held high while busy
    bus.dmem_ready = 1'b0;
    drive(32'h0000_2002, 2'd1, 32'h0000_BEEF);
    push(30'h800, 32'hBEEF_0000, 4'b1100);
    step();
    @(negedge clk);
    chk("bp_valid", 32'(bus.dmem_valid), 32'd1);
    chk("bp_we",    32'(bus.dmem_we),    32'hC);
    step();
    step();
    step();
    bus.dmem_ready = 1'b1;
    step();
    en = 1'b0;
    @(negedge clk);
    chk("bp_valid_drop", 32'(bus.dmem_valid), 32'd0);
    chk("bp_busy_drop",  32'(busy),           32'd0);
    step();
    @(negedge clk);
    chk("bp_no_dup", 32'(bus.dmem_valid), 32'd0);
    step();

    // reserved width is dropped silently
    drive(32'h0000_3000, 2'd3, 32'h5555_5555);
    step();
    en = 1'b0;
    @(negedge clk);
    chk("rsv_valid", 32'(bus.dmem_valid), 32'd0);
    chk("rsv_busy",  32'(busy),           32'd0);
    chk("rsv_unal",  32'(unaligned),      32'd0);
    chk("rsv_addr",  32'(bus.dmem_addr),  32'h800);
    chk("rsv_we",    32'(bus.dmem_we),    32'hC);
    step();

`ifdef AMA_RISCV_STORE_SPLIT_EN
    // word split across the top of the address space
    drive(32'hFFFF_FFFE, 2'd2, 32'h1122_3344);
    push(30'h3FFF_FFFF, 32'h3344_0000, 4'b1100);
    push(30'h000_0000,  32'h0000_1122, 4'b0011);
    step();
    en = 1'b0;
    @(negedge clk);
    chk("split_unal", 32'(unaligned), 32'd0);
    chk("split_busy", 32'(busy),      32'd1);
    step();
    @(negedge clk);
    chk("split_beat1_valid", 32'(bus.dmem_valid), 32'd1);
    step();
    @(negedge clk);
    chk("split_valid_drop", 32'(bus.dmem_valid), 32'd0);
    chk("split_busy_drop",  32'(busy),           32'd0);
    step();

    push(30'h001, 32'hEF00_0000, 4'b1000);
    push(30'h002, 32'h0000_00BE, 4'b0001);
    drive(32'h0000_0007, 2'd1, 32'h0000_BEEF);
    step();
    en = 1'b0;
    step();
    step();

    // reset while beat 1 is pending
    drive(32'h0000_0006, 2'd2, 32'hA1B2_C3D4);
    push(30'h001, 32'hC3D4_0000, 4'b1100);
    step();
    en = 1'b0;
    step();
    bus.dmem_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.dmem_valid), 32'd0);
    chk("mid_rst_busy",  32'(busy),           32'd0);
    chk("mid_rst_addr",  32'(bus.dmem_addr),  32'd0);
    chk("mid_rst_we",    32'(bus.dmem_we),    32'd0);
    bus.dmem_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("mid_rst_no_beat", 32'(bus.dmem_valid), 32'd0);
`else
    // unaligned word: pulse only, outputs untouched
    drive(32'h0000_0005, 2'd2, 32'h1122_3344);
    step();
    en = 1'b0;
    @(negedge clk);
    chk("unal_pulse", 32'(unaligned),      32'd1);
    chk("unal_valid", 32'(bus.dmem_valid), 32'd0);
    chk("unal_busy",  32'(busy),           32'd0);
    chk("unal_addr",  32'(bus.dmem_addr),  32'h800);
    chk("unal_wdata", bus.dmem_wdata,      32'hBEEF_0000);
    chk("unal_we",    32'(bus.dmem_we),    32'hC);
    step();
    @(negedge clk);
    chk("unal_pulse_end", 32'(unaligned), 32'd0);
    step();

    drive(32'h0000_0007, 2'd1, 32'h0000_BEEF);
    step();
    en = 1'b0;
    @(negedge clk);
    chk("unal_half_pulse", 32'(unaligned),      32'd1);
    chk("unal_half_valid", 32'(bus.dmem_valid), 32'd0);
    step();

    // reset while an aligned beat is stalled
    bus.dmem_ready = 1'b0;
    drive(32'h0000_0040, 2'd2, 32'hCAFE_F00D);
    step();
    en = 1'b0;
    @(negedge clk);
    chk("mid_rst_pre_valid", 32'(bus.dmem_valid), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.dmem_valid), 32'd0);
    chk("mid_rst_busy",  32'(busy),           32'd0);
    chk("mid_rst_addr",  32'(bus.dmem_addr),  32'd0);
    chk("mid_rst_wdata", bus.dmem_wdata,      32'd0);
    bus.dmem_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("mid_rst_no_beat", 32'(bus.dmem_valid), 32'd0);
`endif

    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
